// File: rtl/vga_config_ctrl_if.sv
// vga_config_ctrl_if
//   Groups the SPI-side receive/transmit signals, the vertical-blank strobe
//   and the configuration outputs of vga_config_ctrl.
//   master : drives ss, rx_valid, rx_data, vblank_start; observes the outputs
//   slave  : the controller; drives cfg_out, tx_data, tx_load, pending, err
interface vga_config_ctrl_if;
  logic        ss;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        vblank_start;
  logic [31:0] cfg_out;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        pending;
  logic        err;

  modport master (
    output ss, rx_valid, rx_data, vblank_start,
    input  cfg_out, tx_data, tx_load, pending, err
  );

  modport slave (
    input  ss, rx_valid, rx_data, vblank_start,
    output cfg_out, tx_data, tx_load, pending, err
  );
endinterface

// File: rtl/vga_config_ctrl.sv
// vga_config_ctrl
//   SPI-programmed configuration register file for a VGA pipeline. Four
//   8-bit shadow registers are written/read over SPI byte transactions and
//   copied to the active config (cfg_out) only on a vertical-blank strobe,
//   so the active config never changes mid-frame.
// Ports
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus.ss       : SPI chip select, active low (one transaction per low period)
//   bus.rx_valid : one-cycle pulse, bus.rx_data holds a received byte
//   bus.rx_data  : received byte
//   bus.vblank_start : one-cycle pulse at start of vertical blanking
//   bus.cfg_out  : active config {y_off, x_off, colour, 6'b0, mux_sel}
//   bus.tx_data  : byte for the SPI transmit shifter (held between loads)
//   bus.tx_load  : one-cycle pulse, tx_data valid
//   bus.pending  : shadow awaits copy at the next vblank_start
//   bus.err      : sticky protocol error (cleared only by reset)
module vga_config_ctrl #(
  parameter logic [31:0] CFG_RESET = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  vga_config_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CMD   = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_addr;
  logic [31:0] r_shadow;
  logic [31:0] r_cfg;
  logic [7:0]  r_tx_data;
  logic        r_tx_load;
  logic        r_pending;
  logic        r_err;
  // Set once ss has been seen high after reset; blocks a transaction that
  // was already in progress when reset released.
  logic        r_armed;

  logic [7:0]  w_rd_byte;
  logic [7:0]  w_wr_byte;
  logic        w_cmd_bad;

  assign w_cmd_bad = (bus.rx_data[6:2] != 5'd0);

  // Read lane selected directly by the command byte's address field
  always_comb begin
    w_rd_byte = '0;
    case (bus.rx_data[1:0])
      2'd0:    w_rd_byte = r_shadow[7:0];
      2'd1:    w_rd_byte = r_shadow[15:8];
      2'd2:    w_rd_byte = r_shadow[23:16];
      default: w_rd_byte = r_shadow[31:24];
    endcase
  end

  // Address 0 holds only the 2-bit pixel-mux select; upper bits read as 0
  assign w_wr_byte = (r_addr == 2'd0) ? {6'b0, bus.rx_data[1:0]} : bus.rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_shadow  <= CFG_RESET;
      r_cfg     <= CFG_RESET;
      r_tx_data <= '0;
      r_tx_load <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_tx_load <= 1'b0;
      if (bus.ss) r_armed <= 1'b1;

      // Copy reads pre-edge shadow; a same-cycle write below re-sets pending
      if (bus.vblank_start && r_pending) begin
        r_cfg     <= r_shadow;
        r_pending <= 1'b0;
      end

      if (bus.ss) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_armed) r_state <= CMD;
          end
          CMD: begin
            if (bus.rx_valid) begin
              if (w_cmd_bad) begin
                r_err   <= 1'b1;
                r_state <= DRAIN;
              end else if (bus.rx_data[7]) begin
                r_addr  <= bus.rx_data[1:0];
                r_state <= DATA;
              end else begin
                r_tx_data <= w_rd_byte;
                r_tx_load <= 1'b1;
                r_state   <= DRAIN;
              end
            end
          end
          DATA: begin
            if (bus.rx_valid) begin
              case (r_addr)
                2'd0:    r_shadow[7:0]   <= w_wr_byte;
                2'd1:    r_shadow[15:8]  <= w_wr_byte;
                2'd2:    r_shadow[23:16] <= w_wr_byte;
                default: r_shadow[31:24] <= w_wr_byte;
              endcase
              r_pending <= 1'b1;
              r_state   <= DRAIN;
            end
          end
          default: begin
            r_state <= DRAIN;
          end
        endcase
      end
    end
  end

  assign bus.cfg_out = r_cfg;
  assign bus.tx_data = r_tx_data;
  assign bus.tx_load = r_tx_load;
  assign bus.pending = r_pending;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_vga_config_ctrl.sv
// tb_vga_config_ctrl
//   Directed table-driven bench for vga_config_ctrl plus hand-written
//   sequences for abort, write/vblank collision and mid-transaction reset.
module tb_vga_config_ctrl;

  localparam logic [31:0] RST_CFG = 32'hA5C3_7E01;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_fail;
  int   tx_cnt;

  vga_config_ctrl_if bus ();

  vga_config_ctrl #(.CFG_RESET(RST_CFG)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tx_load is stable at the falling edge, so each high cycle counts once
  always @(negedge clk) if (bus.tx_load === 1'b1) tx_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1);
  end

  typedef struct {
    bit          do_spi;
    logic [7:0]  cmd;
    logic [7:0]  data;
    bit          has_data;
    bit          extra;
    bit          vblank;
    logic [31:0] exp_cfg;
    logic        exp_pend;
    logic        exp_err;
    int          exp_tx;
    logic [7:0]  exp_txd;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic vblank();
    bus.vblank_start = 1'b1;
    tick();
    bus.vblank_start = 1'b0;
    tick();
  endtask

  task automatic txn_start();
    bus.ss = 1'b0;
    tick();
  endtask

  task automatic txn_end();
    bus.ss = 1'b1;
    tick();
  endtask

  initial begin
    int tx0;
    n_vec  = 0;
    n_fail = 0;
    tx_cnt = 0;
    bus.ss = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.vblank_start = 1'b0;
    rst_n = 1'b0;

    //            spi cmd    data   hd ex vb  cfg            pd er tx txd
    vecs[0]  = '{1, 8'h81, 8'h5A, 1, 0, 0, 32'hA5C3_7E01, 1, 0, 0, 8'h00};
    vecs[1]  = '{0, 8'h00, 8'h00, 0, 0, 1, 32'hA5C3_5A01, 0, 0, 0, 8'h00};
    vecs[2]  = '{1, 8'h01, 8'h00, 0, 1, 0, 32'hA5C3_5A01, 0, 0, 1, 8'h5A};
    vecs[3]  = '{1, 8'h80, 8'hFF, 1, 0, 0, 32'hA5C3_5A01, 1, 0, 0, 8'h5A};
    vecs[4]  = '{1, 8'h00, 8'h00, 0, 0, 0, 32'hA5C3_5A01, 1, 0, 1, 8'h03};
    vecs[5]  = '{0, 8'h00, 8'h00, 0, 0, 1, 32'hA5C3_5A03, 0, 0, 0, 8'h03};
    vecs[6]  = '{1, 8'h83, 8'h33, 1, 0, 1, 32'h33C3_5A03, 0, 0, 0, 8'h03};
    vecs[7]  = '{1, 8'h82, 8'hC3, 1, 0, 0, 32'h33C3_5A03, 1, 0, 0, 8'h03};
    vecs[8]  = '{0, 8'h00, 8'h00, 0, 0, 1, 32'h33C3_5A03, 0, 0, 0, 8'h03};
    vecs[9]  = '{1, 8'h44, 8'h00, 0, 1, 0, 32'h33C3_5A03, 0, 1, 0, 8'h03};
    vecs[10] = '{1, 8'h82, 8'h10, 1, 0, 0, 32'h33C3_5A03, 1, 1, 0, 8'h03};
    vecs[11] = '{0, 8'h00, 8'h00, 0, 0, 1, 32'h3310_5A03, 0, 1, 0, 8'h03};
    vecs[12] = '{1, 8'h03, 8'h00, 0, 0, 0, 32'h3310_5A03, 0, 1, 1, 8'h33};

    // Reset state
    tick();
    tick();
    chk("rst_cfg",     bus.cfg_out, RST_CFG);
    chk("rst_pending", {31'b0, bus.pending}, 32'd0);
    chk("rst_err",     {31'b0, bus.err}, 32'd0);
    chk("rst_txload",  {31'b0, bus.tx_load}, 32'd0);
    chk("rst_txdata",  {24'b0, bus.tx_data}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int unsigned i = 0; i < 13; i++) begin
      tx0 = tx_cnt;
      if (vecs[i].do_spi) begin
        txn_start();
        send(vecs[i].cmd);
        if (vecs[i].has_data) send(vecs[i].data);
        if (vecs[i].extra) send(8'hFF);
        txn_end();
      end
      if (vecs[i].vblank) vblank();
      chk($sformatf("v%0d_cfg", i),  bus.cfg_out, vecs[i].exp_cfg);
      chk($sformatf("v%0d_pend", i), {31'b0, bus.pending}, {31'b0, vecs[i].exp_pend});
      chk($sformatf("v%0d_err", i),  {31'b0, bus.err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_txcnt", i), 32'(tx_cnt - tx0), 32'(vecs[i].exp_tx));
      chk($sformatf("v%0d_txd", i),  {24'b0, bus.tx_data}, {24'b0, vecs[i].exp_txd});
    end

    // Abort: write command then ss high before the data byte
    txn_start();
    send(8'h82);
    txn_end();
    chk("abort_pend", {31'b0, bus.pending}, 32'd0);
    vblank();
    chk("abort_cfg", bus.cfg_out, 32'h3310_5A03);
    tx0 = tx_cnt;
    txn_start();
    send(8'h02);
    txn_end();
    chk("abort_rd_cnt", 32'(tx_cnt - tx0), 32'd1);
    chk("abort_rd_txd", {24'b0, bus.tx_data}, 32'h10);

    // Collision: data byte to addr 3 in the same cycle as vblank_start
    txn_start();
    send(8'h81);
    send(8'h66);
    txn_end();
    chk("coll_pre_pend", {31'b0, bus.pending}, 32'd1);
    txn_start();
    send(8'h83);
    bus.rx_data      = 8'h44;
    bus.rx_valid     = 1'b1;
    bus.vblank_start = 1'b1;
    tick();
    bus.rx_valid     = 1'b0;
    bus.vblank_start = 1'b0;
    tick();
    chk("coll_cfg",  bus.cfg_out, 32'h3310_6603);
    chk("coll_pend", {31'b0, bus.pending}, 32'd1);
    txn_end();
    vblank();
    chk("coll2_cfg",  bus.cfg_out, 32'h4410_6603);
    chk("coll2_pend", {31'b0, bus.pending}, 32'd0);
    chk("err_sticky", {31'b0, bus.err}, 32'd1);

    // Reset in the middle of a write; ss remains low afterwards
    txn_start();
    send(8'h80);
    rst_n = 1'b0;
    #2;
    chk("mrst_cfg",    bus.cfg_out, RST_CFG);
    chk("mrst_pend",   {31'b0, bus.pending}, 32'd0);
    chk("mrst_err",    {31'b0, bus.err}, 32'd0);
    chk("mrst_txload", {31'b0, bus.tx_load}, 32'd0);
    chk("mrst_txdata", {24'b0, bus.tx_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h12);
    send(8'h81);
    send(8'h12);
    chk("post_rst_pend", {31'b0, bus.pending}, 32'd0);
    txn_end();
    vblank();
    chk("post_rst_cfg", bus.cfg_out, RST_CFG);
    txn_start();
    send(8'h81);
    send(8'h12);
    txn_end();
    chk("rearm_pend", {31'b0, bus.pending}, 32'd1);
    vblank();
    chk("rearm_cfg", bus.cfg_out, 32'hA5C3_1201);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
